sme_param: RTL and testbench

Parameterised successor to the string-match engine (SME).
- A string is streamed in and stored once. Any number of patterns can then be streamed and searched against it.
- Each pattern produces one result: match flag, lowest match start index, and total count of matching start positions.
- New over the previous generation: configurable string/pattern depth and character width, optional case-insensitive compare, match counting, and overflow reporting.
- Sits between the character-stream front end and the result collector / testbench checker.

---
 rtl/sme_param.sv | 192 +++++++++++++++++++
 tb/tb_sme_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sme_param.sv
// Parameterised string-match engine: stores one string, then searches each streamed
// pattern against it (anchors, wildcard, optional case folding, hit counting).
module sme_param #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int CHAR_W  = 8,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  input  logic              nocase,
  output logic              busy,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic [IDX_W:0]    match_count,
  output logic              ovf
);

  localparam int SLEN_W = IDX_W + 1;
  localparam int PLEN_W = $clog2(PAT_MAX + 1);
  localparam int PIDX_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int SX_W   = $clog2(STR_MAX + PAT_MAX + 1);
  localparam logic [SLEN_W-1:0] STR_MAX_L = SLEN_W'(STR_MAX);
  localparam logic [PLEN_W-1:0] PAT_MAX_L = PLEN_W'(PAT_MAX);
  localparam logic [IDX_W:0]    CNT_MAX   = (IDX_W + 1)'(STR_MAX);
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {IDLE, LD_STR, LD_PAT, SEARCH, DONE} state_t;

  function automatic logic is_code(input logic [CHAR_W-1:0] c, input logic [7:0] code);
    return c == CHAR_W'(code);
  endfunction

  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c, input logic en);
    if (en && c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) return c | CHAR_W'(8'h20);
    return c;
  endfunction

  state_t              r_state, w_next;
  logic [CHAR_W-1:0]   r_str [STR_MAX];
  logic [CHAR_W-1:0]   r_pat [PAT_MAX];
  logic [SLEN_W-1:0]   r_str_len, r_s;
  logic [PLEN_W-1:0]   r_pat_len;
  logic                r_nocase, r_ovf_str, r_ovf_pat;
  logic                r_hit_seen;
  logic [IDX_W-1:0]    r_hit_idx;
  logic [IDX_W:0]      r_hit_cnt;
  logic                r_valid, r_match;
  logic [IDX_W-1:0]    r_match_index;
  logic [IDX_W:0]      r_match_count;

  logic                w_str_first, w_str_wr, w_str_full;
  logic                w_pat_first, w_pat_wr, w_pat_full;
  logic [IDX_W-1:0]    w_str_widx, w_prev_idx;
  logic [PIDX_W-1:0]   w_pat_widx, w_pat_last;
  logic                w_start_anc, w_end_anc, w_start_ok, w_end_ok, w_hit, w_last;
  logic [PLEN_W-1:0]   w_body_len;
  logic [SX_W-1:0]     w_end_pos;
  logic [PAT_MAX-1:0]  w_eq;

  // A fresh load starts in IDLE; isstring wins when both strobes are high.
  assign w_str_first = (r_state == IDLE) && isstring;
  assign w_str_wr    = w_str_first || ((r_state == LD_STR) && isstring);
  assign w_str_full  = !w_str_first && (r_str_len == STR_MAX_L);
  assign w_str_widx  = w_str_first ? '0 : r_str_len[IDX_W-1:0];
  assign w_pat_first = (r_state == IDLE) && !isstring && ispattern;
  assign w_pat_wr    = w_pat_first || ((r_state == LD_PAT) && ispattern);
  assign w_pat_full  = !w_pat_first && (r_pat_len == PAT_MAX_L);
  assign w_pat_widx  = w_pat_first ? '0 : r_pat_len[PIDX_W-1:0];

  // NOTE: character stores carry no reset; the length registers alone define valid content.
  always_ff @(posedge clk) begin
    if (w_str_wr && !w_str_full) r_str[w_str_widx] <= chardata;
    if (w_pat_wr && !w_pat_full) r_pat[w_pat_widx] <= chardata;
  end

  assign w_start_anc = (r_pat_len != '0) && is_code(r_pat[0], CH_CARET);
  assign w_pat_last  = PIDX_W'(r_pat_len - PLEN_W'(1));
  assign w_end_anc   = (r_pat_len != '0) && is_code(r_pat[w_pat_last], CH_DOLLAR);
  assign w_body_len  = r_pat_len - PLEN_W'(w_start_anc) - PLEN_W'(w_end_anc);

  for (genvar j = 0; j < PAT_MAX; j++) begin : g_cmp
    logic [SX_W-1:0]   w_sidx;
    logic [PLEN_W:0]   w_pidx;
    logic [CHAR_W-1:0] w_sc, w_pc;
    assign w_sidx  = SX_W'(r_s) + SX_W'(j);
    assign w_pidx  = (PLEN_W + 1)'(j) + (PLEN_W + 1)'(w_start_anc);
    assign w_sc    = (w_sidx < SX_W'(STR_MAX)) ? r_str[w_sidx[IDX_W-1:0]] : '0;
    assign w_pc    = (w_pidx < (PLEN_W + 1)'(PAT_MAX)) ? r_pat[w_pidx[PIDX_W-1:0]] : '0;
    assign w_eq[j] = (PLEN_W'(j) >= w_body_len) || is_code(w_pc, CH_DOT) ||
                     (fold(w_pc, r_nocase) == fold(w_sc, r_nocase));
  end

  // Anchors are word-boundary checks: a space just before / just after the body.
  assign w_prev_idx = IDX_W'(r_s - SLEN_W'(1));
  assign w_end_pos  = SX_W'(r_s) + SX_W'(w_body_len);
  assign w_start_ok = !w_start_anc || (r_s == '0) || is_code(r_str[w_prev_idx], CH_SPACE);
  assign w_end_ok   = !w_end_anc || (w_end_pos == SX_W'(r_str_len)) ||
                      ((w_end_pos < SX_W'(r_str_len)) &&
                       is_code(r_str[w_end_pos[IDX_W-1:0]], CH_SPACE));
  assign w_hit      = (r_s < r_str_len) && (w_end_pos <= SX_W'(r_str_len)) &&
                      (&w_eq) && w_start_ok && w_end_ok;
  assign w_last     = (r_s + SLEN_W'(1)) >= r_str_len;

  // NOTE: next-state is defaulted first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (isstring) w_next = LD_STR;
               else if (ispattern) w_next = LD_PAT;
      LD_STR:  if (!isstring) w_next = IDLE;
      LD_PAT:  if (!ispattern) w_next = SEARCH;
      SEARCH:  if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_str_len     <= '0;
      r_pat_len     <= '0;
      r_nocase      <= 1'b0;
      r_ovf_str     <= 1'b0;
      r_ovf_pat     <= 1'b0;
      r_s           <= '0;
      r_hit_seen    <= 1'b0;
      r_hit_idx     <= '0;
      r_hit_cnt     <= '0;
      r_valid       <= 1'b0;
      r_match       <= 1'b0;
      r_match_index <= '0;
      r_match_count <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      if (w_str_wr) begin
        if (w_str_first) begin
          r_str_len <= SLEN_W'(1);
          r_ovf_str <= 1'b0;
        end else if (w_str_full) r_ovf_str <= 1'b1;
        else r_str_len <= r_str_len + SLEN_W'(1);
      end
      if (w_pat_wr) begin
        if (w_pat_first) begin
          r_pat_len <= PLEN_W'(1);
          r_ovf_pat <= 1'b0;
          r_nocase  <= nocase;
        end else if (w_pat_full) r_ovf_pat <= 1'b1;
        else r_pat_len <= r_pat_len + PLEN_W'(1);
      end
      if ((r_state == LD_PAT) && !ispattern) begin
        r_s        <= '0;
        r_hit_seen <= 1'b0;
        r_hit_idx  <= '0;
        r_hit_cnt  <= '0;
      end
      if (r_state == SEARCH) begin
        r_s <= r_s + SLEN_W'(1);
        if (w_hit) begin
          if (!r_hit_seen) begin
            r_hit_seen <= 1'b1;
            r_hit_idx  <= r_s[IDX_W-1:0];
          end
          if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + (IDX_W + 1)'(1);
        end
      end
      if (r_state == DONE) begin
        r_valid       <= 1'b1;
        r_match       <= r_hit_seen;
        r_match_index <= r_hit_idx;
        r_match_count <= r_hit_cnt;
      end
    end
  end

  assign busy        = (r_state == SEARCH) || (r_state == DONE);
  assign valid       = r_valid;
  assign match       = r_match;
  assign match_index = r_match_index;
  assign match_count = r_match_count;
  assign ovf         = r_ovf_str || r_ovf_pat;

endmodule

// File: tb/tb_sme_param.sv
// Directed bench for sme_param: result values, result latency, anchors, case folding,
// overflow, reset abort and strobes while busy.
module tb_sme_param;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] chardata = '0;
  logic       isstring = 1'b0;
  logic       ispattern = 1'b0;
  logic       nocase = 1'b0;
  logic       busy, valid, match, ovf;
  logic [4:0] match_index;
  logic [5:0] match_count;
  int checks = 0;
  int errors = 0;

  sme_param dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .nocase(nocase), .busy(busy), .valid(valid),
    .match(match), .match_index(match_index), .match_count(match_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic load_str(input string s);
    @(negedge clk);
    for (int i = 0; i < s.len(); i++) begin
      isstring = 1'b1;
      chardata = s[i];
      @(negedge clk);
    end
    isstring = 1'b0;
    chardata = '0;
  endtask

  // Streams a pattern and waits (bounded) for valid. lat counts edges after edge T.
  // disturb raises both strobes for edges T+2..T+5; rst_at pulses reset at edge T+rst_at.
  task automatic run_pat(input string p, input bit nc, input bit disturb, input int rst_at,
                         output bit got, output int lat, output bit busy_ok);
    got = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    for (int i = 0; i < p.len(); i++) begin
      ispattern = 1'b1;
      nocase    = (i == 0) ? nc : !nc;
      chardata  = p[i];
      @(negedge clk);
    end
    ispattern = 1'b0;
    nocase    = 1'b0;
    chardata  = '0;
    @(posedge clk);
    #1;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        got = 1'b1;
        lat = k;
      end else if (busy !== 1'b1) busy_ok = 1'b0;
      reset     = ((k + 1) == rst_at);
      isstring  = disturb && (k + 1) >= 2 && (k + 1) <= 5;
      ispattern = disturb && (k + 1) >= 2 && (k + 1) <= 5;
      chardata  = disturb ? 8'h7A : 8'h00;
    end
    reset     = 1'b0;
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, valid, match, ovf} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, valid, match, ovf}); end
    checks++; if (match_index !== 5'd0) begin errors++;
      $display("FAIL reset_index: got %0d expected 0", match_index); end
    checks++; if (match_count !== 6'd0) begin errors++;
      $display("FAIL reset_count: got %0d expected 0", match_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit got, bok;
    int lat;
    load_str("hello world");
    run_pat("wor", 1'b0, 1'b0, -1, got, lat, bok);
    checks++; if (lat !== 12) begin errors++;
      $display("FAIL basic_latency: got %0d expected 12 (got_valid=%0d)", lat, got); end
    checks++; if (bok !== 1'b1) begin errors++;
      $display("FAIL basic_busy: got %0d expected 1", bok); end
    checks++; if (match !== 1'b1) begin errors++;
      $display("FAIL basic_match: got %0d expected 1", match); end
    checks++; if (match_index !== 5'd6) begin errors++;
      $display("FAIL basic_index: got %0d expected 6", match_index); end
    checks++; if (match_count !== 6'd1) begin errors++;
      $display("FAIL basic_count: got %0d expected 1", match_count); end
    @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++;
      $display("FAIL basic_valid_pulse: got %0d expected 0", valid); end
    checks++; if (match !== 1'b1 || match_index !== 5'd6) begin errors++;
      $display("FAIL basic_hold: got %0d/%0d expected 1/6", match, match_index); end
  endtask

  task automatic test_patterns();
    string pats[9] = '{"o", "^o", "^wor", "ld$", "l.$", "hel$", "h.l", "HELLO", "HELLO"};
    bit    ncs[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit    ms[9]   = '{1, 0, 1, 1, 1, 0, 1, 1, 0};
    int    idxs[9] = '{4, 0, 6, 9, 3, 0, 0, 0, 0};
    int    cnts[9] = '{2, 0, 1, 1, 2, 0, 1, 1, 0};
    bit got, bok;
    int lat;
    for (int v = 0; v < 9; v++) begin
      run_pat(pats[v], ncs[v], 1'b0, -1, got, lat, bok);
      checks++; if (lat !== 12) begin errors++;
        $display("FAIL pat_latency[%s]: got %0d expected 12", pats[v], lat); end
      checks++; if (match !== ms[v]) begin errors++;
        $display("FAIL pat_match[%s]: got %0d expected %0d", pats[v], match, ms[v]); end
      checks++; if (match_index !== 5'(idxs[v])) begin errors++;
        $display("FAIL pat_index[%s]: got %0d expected %0d", pats[v], match_index, idxs[v]); end
      checks++; if (match_count !== 6'(cnts[v])) begin errors++;
        $display("FAIL pat_count[%s]: got %0d expected %0d", pats[v], match_count, cnts[v]); end
    end
  endtask

  task automatic test_overflow();
    string s = "";
    bit got, bok;
    int lat;
    for (int i = 0; i < 40; i++) begin
      if (i < 32) s = {s, "x"};
      else if (i == 32) s = {s, "a"};
      else if (i == 33) s = {s, "b"};
      else if (i == 34) s = {s, "c"};
      else s = {s, "y"};
    end
    load_str(s);
    run_pat("abc", 1'b0, 1'b0, -1, got, lat, bok);
    checks++; if (ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_string: got %0d expected 1", ovf); end
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL ovf_latency: got %0d expected 33", lat); end
    checks++; if (match !== 1'b0 || match_count !== 6'd0) begin errors++;
      $display("FAIL ovf_dropped: got %0d/%0d expected 0/0", match, match_count); end
    run_pat("xxx", 1'b0, 1'b0, -1, got, lat, bok);
    checks++; if (match !== 1'b1 || match_index !== 5'd0 || match_count !== 6'd30) begin
      errors++;
      $display("FAIL ovf_full_string: got %0d/%0d/%0d expected 1/0/30",
               match, match_index, match_count); end
    run_pat("xxxxxxxxzz", 1'b0, 1'b0, -1, got, lat, bok);
    checks++; if (ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_pattern: got %0d expected 1", ovf); end
    checks++; if (match !== 1'b1 || match_count !== 6'd25) begin errors++;
      $display("FAIL ovf_truncated: got %0d/%0d expected 1/25", match, match_count); end
    load_str("hello world");
    checks++; if (ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_pattern_held: got %0d expected 1", ovf); end
    run_pat("wor", 1'b0, 1'b0, -1, got, lat, bok);
    checks++; if (ovf !== 1'b0 || match_index !== 5'd6) begin errors++;
      $display("FAIL ovf_cleared: got %0d/%0d expected 0/6", ovf, match_index); end
  endtask

  task automatic test_reset_abort();
    bit got, bok;
    int lat;
    load_str("hello world");
    run_pat("wor", 1'b0, 1'b0, 3, got, lat, bok);
    checks++; if (got !== 1'b0) begin errors++;
      $display("FAIL abort_no_valid: got %0d expected 0", got); end
    checks++; if ({busy, valid, match, ovf} !== 4'b0000 || match_index !== 5'd0 ||
                  match_count !== 6'd0) begin errors++;
      $display("FAIL abort_outputs: got %b/%0d/%0d expected 0000/0/0",
               {busy, valid, match, ovf}, match_index, match_count); end
    run_pat("o", 1'b0, 1'b0, -1, got, lat, bok);
    checks++; if (lat !== 2) begin errors++;
      $display("FAIL abort_empty_latency: got %0d expected 2", lat); end
    checks++; if (match !== 1'b0 || match_count !== 6'd0) begin errors++;
      $display("FAIL abort_cleared_string: got %0d/%0d expected 0/0", match, match_count); end
  endtask

  task automatic test_back_to_back();
    bit got, bok;
    int lat;
    load_str("hello world");
    run_pat("o", 1'b0, 1'b1, -1, got, lat, bok);
    checks++; if (lat !== 12 || bok !== 1'b1) begin errors++;
      $display("FAIL busy_strobe_timing: got %0d/%0d expected 12/1", lat, bok); end
    checks++; if (match !== 1'b1 || match_index !== 5'd4 || match_count !== 6'd2) begin
      errors++;
      $display("FAIL busy_strobe_result: got %0d/%0d/%0d expected 1/4/2",
               match, match_index, match_count); end
    run_pat("wor", 1'b0, 1'b0, -1, got, lat, bok);
    checks++; if (match !== 1'b1 || match_index !== 5'd6 || match_count !== 6'd1) begin
      errors++;
      $display("FAIL busy_strobe_string_kept: got %0d/%0d/%0d expected 1/6/1",
               match, match_index, match_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_overflow();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
